// File: rtl/pu_riscv_if_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, arbitrates redirects against sequential fetch,
// issues in-order memory requests and drops stale parcels after every redirect.
module pu_riscv_if_fetch_ctrl #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] PC_INIT     = 'h200,
  parameter int              FETCH_BYTES = 4,
  parameter int              MAX_OUT     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall,
  input  logic            du_flush,
  input  logic            st_flush,
  input  logic            bu_flush,
  input  logic [XLEN-1:0] du_nxt_pc,
  input  logic [XLEN-1:0] st_nxt_pc,
  input  logic [XLEN-1:0] bu_nxt_pc,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_adr,
  input  logic            mem_ack,
  input  logic            mem_parcel_valid,
  output logic            parcel_keep,
  output logic            if_flush,
  output logic [XLEN-1:0] if_nxt_pc,
  output logic [3:0]      out_cnt
);

  localparam logic [XLEN-1:0] FB      = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] FB_MASK = ~(FB - 1'b1);
  localparam logic [3:0]      MAX_CNT = 4'(MAX_OUT);

  typedef enum logic {RST_WAIT, RUN} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [3:0]      kill_cnt;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            ack_acc;
  logic            resp_acc;
  logic [3:0]      out_cnt_next;

  always_comb begin
    redirect    = 1'b1;
    redirect_pc = pc;
    if (du_flush)                  redirect_pc = du_nxt_pc;
    else if (st_flush)             redirect_pc = st_nxt_pc;
    else if (bu_flush)             redirect_pc = bu_nxt_pc;
    else if (bp_taken && !id_stall) redirect_pc = bp_target;
    else                           redirect = 1'b0;
  end

  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign resp_acc = mem_parcel_valid && (out_cnt != 4'd0);

  // A landing response frees a slot this cycle, so a full counter need not stall it.
  assign mem_req = (state == RUN) && !id_stall && !redirect &&
                   ((out_cnt < MAX_CNT) || resp_acc);

  assign ack_acc      = mem_req && mem_ack;
  assign out_cnt_next = out_cnt + {3'd0, ack_acc} - {3'd0, resp_acc};
  assign parcel_keep  = resp_acc && (kill_cnt == 4'd0) && !redirect;
  assign mem_adr      = pc;
  assign if_nxt_pc    = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_WAIT;
      pc       <= PC_INIT;
      out_cnt  <= 4'd0;
      kill_cnt <= 4'd0;
      if_flush <= 1'b0;
    end else begin
      state    <= RUN;
      if_flush <= redirect;
      out_cnt  <= out_cnt_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc       <= redirect_pc;
        kill_cnt <= out_cnt_next;
      end else begin
        if (ack_acc)
          pc <= (pc & FB_MASK) + FB;
        if (resp_acc && (kill_cnt != 4'd0))
          kill_cnt <= kill_cnt - 4'd1;
      end
    end
  end

endmodule
